hamming_codec: RTL and testbench

//   Registered Hamming(12,8) single-error-correcting codec.

---
 rtl/hamming_codec.sv | 126 ++++++++++++
 tb/tb_hamming_codec.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_codec.sv
`default_nettype none
// ============================================================================
// Module   : hamming_codec
// Purpose  : Registered Hamming(12,8) SEC encoder and decoder, independent paths.
// Revision : 1.0
// ============================================================================
module hamming_codec (
    input  logic        clk,
    input  logic        rst,
    input  logic        enc_valid_in,
    input  logic [7:0]  enc_data,
    output logic        enc_valid,
    output logic [11:0] enc_code,
    input  logic        dec_valid_in,
    input  logic [11:0] dec_code,
    output logic        dec_valid,
    output logic [7:0]  dec_data,
    output logic [3:0]  dec_syn,
    output logic        dec_err,
    output logic        dec_bad
);

    localparam logic [3:0] c_LAST_POS = 4'd12;

    // Code positions (1-based) whose index has bit k set; used for syndrome bit k.
    function automatic logic [11:0] syn_mask(input int k);
        logic [11:0] m;
        m = '0;
        for (int p = 1; p <= 12; p++) begin
            m[p-1] = ((p >> k) & 1) != 0;
        end
        return m;
    endfunction

    function automatic logic [7:0] extract(input logic [11:0] c);
        return {c[11], c[10], c[9], c[8], c[6], c[5], c[4], c[2]};
    endfunction

    // ------------------------------------------------------------------
    // Encode core
    // ------------------------------------------------------------------
    logic        w_p1;
    logic        w_p2;
    logic        w_p4;
    logic        w_p8;
    logic [11:0] w_enc_code;

    assign w_p1 = enc_data[0] ^ enc_data[1] ^ enc_data[3] ^ enc_data[4] ^ enc_data[6];
    assign w_p2 = enc_data[0] ^ enc_data[2] ^ enc_data[3] ^ enc_data[5] ^ enc_data[6];
    assign w_p4 = enc_data[1] ^ enc_data[2] ^ enc_data[3] ^ enc_data[7];
    assign w_p8 = enc_data[4] ^ enc_data[5] ^ enc_data[6] ^ enc_data[7];

    assign w_enc_code = {enc_data[7], enc_data[6], enc_data[5], enc_data[4], w_p8,
                         enc_data[3], enc_data[2], enc_data[1], w_p4,
                         enc_data[0], w_p2, w_p1};

    // ------------------------------------------------------------------
    // Decode core
    // ------------------------------------------------------------------
    logic [3:0]  w_syn;
    logic [11:0] w_flip;
    logic [11:0] w_corr;
    logic        w_err;
    logic        w_bad;

    for (genvar k = 0; k < 4; k++) begin : g_syn
        localparam logic [11:0] c_MASK = syn_mask(k);
        assign w_syn[k] = ^(dec_code & c_MASK);
    end

    // Out-of-range syndromes (13..15) select no position, so the word passes raw.
    for (genvar i = 0; i < 12; i++) begin : g_flip
        assign w_flip[i] = (w_syn == 4'(i + 1));
    end

    assign w_corr = dec_code ^ w_flip;
    assign w_err  = (w_syn != 4'd0) && (w_syn <= c_LAST_POS);
    assign w_bad  = (w_syn > c_LAST_POS);

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    logic        r_enc_valid;
    logic [11:0] r_enc_code;
    logic        r_dec_valid;
    logic [7:0]  r_dec_data;
    logic [3:0]  r_dec_syn;
    logic        r_dec_err;
    logic        r_dec_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_enc_valid <= 1'b0;
            r_enc_code  <= '0;
        end else begin
            r_enc_valid <= enc_valid_in;
            r_enc_code  <= w_enc_code;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dec_valid <= 1'b0;
            r_dec_data  <= '0;
            r_dec_syn   <= '0;
            r_dec_err   <= 1'b0;
            r_dec_bad   <= 1'b0;
        end else begin
            r_dec_valid <= dec_valid_in;
            r_dec_data  <= extract(w_corr);
            r_dec_syn   <= w_syn;
            r_dec_err   <= w_err;
            r_dec_bad   <= w_bad;
        end
    end

    assign enc_valid = r_enc_valid;
    assign enc_code  = r_enc_code;
    assign dec_valid = r_dec_valid;
    assign dec_data  = r_dec_data;
    assign dec_syn   = r_dec_syn;
    assign dec_err   = r_dec_err;
    assign dec_bad   = r_dec_bad;

endmodule
`default_nettype wire

// File: tb/tb_hamming_codec.sv
`default_nettype none
// ============================================================================
// Module   : tb_hamming_codec
// Purpose  : Directed vectors plus cycle-by-cycle comparison against a position-arithmetic model.
// Revision : 1.0
// ============================================================================
module tb_hamming_codec;

    logic        clk;
    logic        rst;
    logic        enc_valid_in;
    logic [7:0]  enc_data;
    logic        enc_valid;
    logic [11:0] enc_code;
    logic        dec_valid_in;
    logic [11:0] dec_code;
    logic        dec_valid;
    logic [7:0]  dec_data;
    logic [3:0]  dec_syn;
    logic        dec_err;
    logic        dec_bad;

    int checks = 0;
    int errors = 0;

    hamming_codec dut (
        .clk          (clk),
        .rst          (rst),
        .enc_valid_in (enc_valid_in),
        .enc_data     (enc_data),
        .enc_valid    (enc_valid),
        .enc_code     (enc_code),
        .dec_valid_in (dec_valid_in),
        .dec_code     (dec_code),
        .dec_valid    (dec_valid),
        .dec_data     (dec_data),
        .dec_syn      (dec_syn),
        .dec_err      (dec_err),
        .dec_bad      (dec_bad)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a codeword is valid when the XOR of the indices of its set positions is zero.
    function automatic int dpos(input int i);
        int tbl [8];
        tbl = '{3, 5, 6, 7, 9, 10, 11, 12};
        return tbl[i];
    endfunction

    function automatic logic [11:0] m_enc(input logic [7:0] d);
        logic [11:0] w;
        int x;
        w = '0;
        x = 0;
        for (int i = 0; i < 8; i++) begin
            if (d[i]) begin
                w[dpos(i)-1] = 1'b1;
                x ^= dpos(i);
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (((x >> k) & 1) != 0) w[(1 << k) - 1] = 1'b1;
        end
        return w;
    endfunction

    function automatic logic [3:0] m_syn(input logic [11:0] c);
        int x;
        x = 0;
        for (int p = 1; p <= 12; p++) begin
            if (c[p-1]) x ^= p;
        end
        return 4'(x);
    endfunction

    function automatic logic [7:0] m_dec(input logic [11:0] c);
        logic [11:0] w;
        logic [7:0]  d;
        int s;
        w = c;
        s = int'(m_syn(c));
        if (s >= 1 && s <= 12) w[s-1] = ~w[s-1];
        for (int i = 0; i < 8; i++) d[i] = w[dpos(i)-1];
        return d;
    endfunction

    // Every-cycle compare against the model, using inputs seen at the edge.
    always @(posedge clk) begin
        logic        s_rst;
        logic        s_ev;
        logic [7:0]  s_ed;
        logic        s_dv;
        logic [11:0] s_dc;
        int          s;
        s_rst = rst;
        s_ev  = enc_valid_in;
        s_ed  = enc_data;
        s_dv  = dec_valid_in;
        s_dc  = dec_code;
        #1;
        s = int'(m_syn(s_dc));
        if (s_rst) begin
            check("rst_enc_valid", 32'(enc_valid), 32'd0);
            check("rst_enc_code",  32'(enc_code),  32'd0);
            check("rst_dec_valid", 32'(dec_valid), 32'd0);
            check("rst_dec_data",  32'(dec_data),  32'd0);
            check("rst_dec_syn",   32'(dec_syn),   32'd0);
            check("rst_dec_err",   32'(dec_err),   32'd0);
            check("rst_dec_bad",   32'(dec_bad),   32'd0);
        end else begin
            check("mdl_enc_valid", 32'(enc_valid), 32'(s_ev));
            check("mdl_enc_code",  32'(enc_code),  32'(m_enc(s_ed)));
            check("mdl_dec_valid", 32'(dec_valid), 32'(s_dv));
            check("mdl_dec_data",  32'(dec_data),  32'(m_dec(s_dc)));
            check("mdl_dec_syn",   32'(dec_syn),   32'(s));
            check("mdl_dec_err",   32'(dec_err),   32'(s >= 1 && s <= 12));
            check("mdl_dec_bad",   32'(dec_bad),   32'(s >= 13));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_dec(input logic [11:0] c);
        @(negedge clk);
        dec_valid_in = 1'b1;
        dec_code     = c;
        step();
    endtask

    initial begin
        logic [7:0] sent [$];
        logic [7:0] exp_b;
        int         got;
        rst          = 1'b1;
        enc_valid_in = 1'b0;
        enc_data     = '0;
        dec_valid_in = 1'b0;
        dec_code     = '0;
        step();
        step();

        // Hand-computed encode vectors
        @(negedge clk);
        rst          = 1'b0;
        enc_valid_in = 1'b1;
        enc_data     = 8'h00;
        step();
        check("enc_00", 32'(enc_code), 32'h000);
        check("enc_valid_lat", 32'(enc_valid), 32'd1);
        @(negedge clk); enc_data = 8'h01; step();
        check("enc_01", 32'(enc_code), 32'h007);
        @(negedge clk); enc_data = 8'hFF; step();
        check("enc_FF", 32'(enc_code), 32'hF77);

        // Single-bit errors on every position of 0xF77
        for (int p = 1; p <= 12; p++) begin
            logic [11:0] c;
            c = 12'hF77;
            c[p-1] = ~c[p-1];
            drive_dec(c);
            check("serr_data", 32'(dec_data), 32'hFF);
            check("serr_syn",  32'(dec_syn),  32'(p));
            check("serr_err",  32'(dec_err),  32'd1);
            check("serr_bad",  32'(dec_bad),  32'd0);
        end
        drive_dec(12'hF67);
        check("pos5_data", 32'(dec_data), 32'hFF);
        check("pos5_syn",  32'(dec_syn),  32'd5);

        drive_dec(12'h006);
        check("par1_data", 32'(dec_data), 32'h01);
        check("par1_syn",  32'(dec_syn),  32'd1);
        check("par1_err",  32'(dec_err),  32'd1);

        drive_dec(12'h801);
        check("bad_syn",  32'(dec_syn),  32'd13);
        check("bad_bad",  32'(dec_bad),  32'd1);
        check("bad_err",  32'(dec_err),  32'd0);
        check("bad_data", 32'(dec_data), 32'h80);

        drive_dec(12'h000);
        check("clean_syn", 32'(dec_syn), 32'd0);
        check("clean_err", 32'(dec_err), 32'd0);

        // Loopback: enc_code chained into dec_code, counter 0x00..0xFF then wrap
        got = 0;
        for (int i = 0; i < 262; i++) begin
            @(negedge clk);
            enc_valid_in = (i < 258);
            enc_data     = 8'(i);
            dec_code     = enc_code;
            dec_valid_in = enc_valid;
            if (i >= 1 && i <= 258) ; else dec_valid_in = 1'b0;
            if (enc_valid_in) sent.push_back(enc_data);
            step();
            if (dec_valid) begin
                if (sent.size() == 0) begin
                    check("loop_extra", 32'd1, 32'd0);
                end else begin
                    exp_b = sent.pop_front();
                    check("loop_data", 32'(dec_data), 32'(exp_b));
                    check("loop_err",  32'(dec_err),  32'd0);
                    check("loop_bad",  32'(dec_bad),  32'd0);
                    got++;
                end
            end
        end
        check("loop_count", 32'(got), 32'd258);

        // Reset mid-stream
        @(negedge clk);
        enc_valid_in = 1'b1;
        enc_data     = 8'h5A;
        dec_valid_in = 1'b1;
        dec_code     = 12'h801;
        step();
        @(negedge clk);
        rst = 1'b1;
        step();
        check("midrst_enc_valid", 32'(enc_valid), 32'd0);
        check("midrst_enc_code",  32'(enc_code),  32'd0);
        check("midrst_dec_bad",   32'(dec_bad),   32'd0);
        @(negedge clk);
        rst          = 1'b0;
        enc_valid_in = 1'b0;
        dec_valid_in = 1'b0;
        step();
        check("post_rst_enc_valid", 32'(enc_valid), 32'd0);
        check("post_rst_dec_valid", 32'(dec_valid), 32'd0);
        @(negedge clk);
        enc_valid_in = 1'b1;
        enc_data     = 8'h01;
        dec_valid_in = 1'b1;
        dec_code     = 12'h007;
        step();
        check("first_enc_valid", 32'(enc_valid), 32'd1);
        check("first_enc_code",  32'(enc_code),  32'h007);
        check("first_dec_valid", 32'(dec_valid), 32'd1);
        check("first_dec_data",  32'(dec_data),  32'h01);
        @(negedge clk);
        enc_valid_in = 1'b0;
        dec_valid_in = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
